// File: rtl/mem_crypt_engine.sv
// mem_crypt_engine: memory-to-memory add-rotate block cipher with optional
// CBC-style chaining. It walks LEN words from a source base to a destination
// base through a single shared memory port, one word every three cycles.
module mem_crypt_engine #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 8,
  parameter int ROT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              encrypt,
  input  logic              chain_en,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] iv,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Command fields captured on an accepted start
  logic              encrypt_q;
  logic              chain_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] key_q;

  // Word index and chaining value for the current word
  logic [LEN_W-1:0]  idx_p0;
  logic [DATA_W-1:0] prev_p0;
  // Results computed in WAIT, consumed in WRITE
  logic [DATA_W-1:0] prev_next_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              err_q;

  logic              accept;
  logic              last;
  logic [DATA_W-1:0] idx_ext;
  logic [DATA_W-1:0] chain_term;
  logic [DATA_W-1:0] y_enc;
  logic [DATA_W-1:0] y_dec;

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x);
    return (x << ROT) | (x >> (DATA_W - ROT));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x);
    return (x >> ROT) | (x << (DATA_W - ROT));
  endfunction

  assign accept     = (state_q == IDLE) && start;
  assign last       = (idx_p0 == (len_q - LEN_W'(1)));
  assign idx_ext    = DATA_W'(idx_p0);
  assign chain_term = chain_q ? prev_p0 : '0;

  // Encrypt mixes chain and key before the index add and rotate; decrypt
  // undoes the steps in reverse order, using the ciphertext read as chain.
  assign y_enc = rotl(((mem_rdata ^ chain_term) ^ key_q) + idx_ext);
  assign y_dec = ((rotr(mem_rdata) - idx_ext) ^ key_q) ^ chain_term;

  assign err       = err_q;
  assign mem_wdata = wdata_p1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and memory strobe/address decode
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FIN : READ;
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = src_q + ADDR_W'(idx_p0);
        state_d   = WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = dst_q + ADDR_W'(idx_p0);
        state_d   = last ? FIN : READ;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture command fields when a start is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      encrypt_q <= encrypt;
      chain_q   <= chain_en;
      src_q     <= src_addr;
      dst_q     <= dst_addr;
      len_q     <= len;
      key_q     <= key;
    end
  end

  // Index, chaining value, write data and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_p0       <= '0;
      prev_p0      <= '0;
      prev_next_p1 <= '0;
      wdata_p1     <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            idx_p0  <= '0;
            prev_p0 <= iv;
            err_q   <= (len == '0);
          end
        end
        // ---- WAIT: read data arrives, compute the word ----
        WAIT: begin
          wdata_p1     <= encrypt_q ? y_enc : y_dec;
          prev_next_p1 <= encrypt_q ? y_enc : mem_rdata;
        end
        // ---- WRITE: commit chain value, advance index ----
        WRITE: begin
          prev_p0 <= prev_next_p1;
          if (!last) begin
            idx_p0 <= idx_p0 + LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_crypt_engine.sv
// tb_mem_crypt_engine: randomized and directed checks of mem_crypt_engine
// against a word-level reference model of the cipher and a memory model.
module tb_mem_crypt_engine;
  localparam int DW  = 19;
  localparam int AW  = 14;
  localparam int LW  = 8;
  localparam int ROT = 3;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, encrypt, chain_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] key, iv;
  logic          busy, done, err, mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, mem_wdata;

  logic [DW-1:0] mem     [MSZ];
  logic [DW-1:0] exp_mem [MSZ];

  logic          tb_we;
  logic [AW-1:0] tb_wa;
  logic [DW-1:0] tb_wd;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_total = 0;

  always #5 clk = ~clk;

  mem_crypt_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .ROT(ROT)) dut (
    .clk(clk), .rst(rst), .start(start), .encrypt(encrypt), .chain_en(chain_en),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .key(key), .iv(iv),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata)
  );

  // Memory: one-cycle read latency; the bench preloads through tb_we
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_total <= wr_total + 1;
    end else if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end
  end

  function automatic logic [DW-1:0] ref_rotl(input logic [DW-1:0] x);
    logic [2*DW-1:0] d;
    d = {x, x};
    return d[2*DW-1-ROT -: DW];
  endfunction

  function automatic logic [DW-1:0] ref_rotr(input logic [DW-1:0] x);
    logic [2*DW-1:0] d;
    d = {x, x};
    return d[DW-1+ROT -: DW];
  endfunction

  // Word-by-word reference of a whole command applied to exp_mem
  task automatic model_cmd(input bit enc, input bit ch, input int s, input int d,
                           input int l, input logic [DW-1:0] k, input logic [DW-1:0] v);
    logic [DW-1:0] prev, x, m, y;
    prev = v;
    for (int j = 0; j < l; j++) begin
      x = exp_mem[(s + j) % MSZ];
      m = ch ? prev : '0;
      if (enc) begin
        y = ref_rotl(((x ^ m) ^ k) + DW'(j));
        prev = y;
      end else begin
        y = ((ref_rotr(x) - DW'(j)) ^ k) ^ m;
        prev = x;
      end
      exp_mem[(d + j) % MSZ] = y;
    end
  endtask

  task automatic put(input int a, input logic [DW-1:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = AW'(a % MSZ);
    tb_wd = v;
    exp_mem[a % MSZ] = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Issue one command and observe it until done (bounded)
  task automatic run_cmd(input bit enc, input bit ch, input int s, input int d, input int l,
                         input logic [DW-1:0] k, input logic [DW-1:0] v, input bit tog,
                         output int cyc, output int bsy, output bit err_done,
                         output int rds, output int wrs, output int both);
    cyc = -1; bsy = 0; err_done = 1'b0; rds = 0; wrs = 0; both = 0;
    @(negedge clk);
    encrypt = enc; chain_en = ch; src_addr = AW'(s % MSZ); dst_addr = AW'(d % MSZ);
    len = LW'(l); key = k; iv = v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (busy) bsy++;
      if (mem_rd_en) rds++;
      if (mem_wr_en) wrs++;
      if (mem_rd_en && mem_wr_en) both++;
      if (done) begin
        cyc = n;
        err_done = err;
        start = 1'b0;
        break;
      end
      if (tog) begin
        start = 1'($urandom);
        key = DW'($urandom);
        len = LW'($urandom);
        src_addr = AW'($urandom);
        encrypt = 1'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
    n_cmp++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got %b want 00", {mem_rd_en, mem_wr_en}); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL reset_addr_data got %0h/%0h want 0/0", mem_addr, mem_wdata); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, bsy, rds, wrs, both; bit e;
    put(400, 19'd10); put(401, 19'd11);
    model_cmd(1, 0, 400, 300, 2, '0, '0);
    run_cmd(1, 0, 400, 300, 2, '0, '0, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (mem[300] !== 19'd80) begin n_bad++; $display("FAIL basic_w0 got %0d want 80", mem[300]); end
    n_cmp++; if (mem[301] !== 19'd96) begin n_bad++; $display("FAIL basic_w1 got %0d want 96", mem[301]); end
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL basic_latency got %0d want 7", cyc); end
    n_cmp++; if (bsy !== 6) begin n_bad++; $display("FAIL basic_busy got %0d want 6", bsy); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0b want 0", e); end
    n_cmp++; if (rds !== 2 || wrs !== 2 || both !== 0) begin n_bad++; $display("FAIL basic_strobes got rd=%0d wr=%0d both=%0d want 2/2/0", rds, wrs, both); end
  endtask

  task automatic test_chain();
    int cyc, bsy, rds, wrs, both; bit e;
    put(400, 19'd10); put(401, 19'd11);
    run_cmd(1, 1, 400, 600, 2, '0, 19'd1, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (mem[600] !== 19'd88) begin n_bad++; $display("FAIL chain_enc_w0 got %0d want 88", mem[600]); end
    n_cmp++; if (mem[601] !== 19'd672) begin n_bad++; $display("FAIL chain_enc_w1 got %0d want 672", mem[601]); end
    run_cmd(0, 1, 600, 500, 2, '0, 19'd1, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (mem[500] !== 19'd10) begin n_bad++; $display("FAIL chain_dec_w0 got %0d want 10", mem[500]); end
    n_cmp++; if (mem[501] !== 19'd11) begin n_bad++; $display("FAIL chain_dec_w1 got %0d want 11", mem[501]); end
    exp_mem[600] = mem[600]; exp_mem[601] = mem[601];
    exp_mem[500] = mem[500]; exp_mem[501] = mem[501];
  endtask

  task automatic test_rotate_wrap();
    int cyc, bsy, rds, wrs, both; bit e;
    put(700, 19'h70000);
    model_cmd(1, 0, 700, 710, 1, '0, '0);
    run_cmd(1, 0, 700, 710, 1, '0, '0, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (mem[710] !== 19'h00007) begin n_bad++; $display("FAIL rot_enc got %0h want 7", mem[710]); end
    model_cmd(0, 0, 710, 720, 1, '0, '0);
    run_cmd(0, 0, 710, 720, 1, '0, '0, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (mem[720] !== 19'h70000) begin n_bad++; $display("FAIL rot_dec got %0h want 70000", mem[720]); end
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rot_latency got %0d want 4", cyc); end
  endtask

  task automatic test_round_trip();
    int cyc, bsy, rds, wrs, both; bit e;
    logic [DW-1:0] v;
    for (int ch = 0; ch < 2; ch++) begin
      v = DW'($urandom);
      for (int j = 0; j < 8; j++) put(400 + j, DW'(j + 10));
      model_cmd(1, ch[0], 400, 300, 8, 19'h15A5A, v);
      run_cmd(1, ch[0], 400, 300, 8, 19'h15A5A, v, 0, cyc, bsy, e, rds, wrs, both);
      for (int j = 0; j < 8; j++) begin
        n_cmp++; if (mem[300 + j] !== exp_mem[300 + j]) begin n_bad++; $display("FAIL rt_cipher ch=%0d j=%0d got %0h want %0h", ch, j, mem[300 + j], exp_mem[300 + j]); end
      end
      model_cmd(0, ch[0], 300, 500, 8, 19'h15A5A, v);
      run_cmd(0, ch[0], 300, 500, 8, 19'h15A5A, v, 0, cyc, bsy, e, rds, wrs, both);
      for (int j = 0; j < 8; j++) begin
        n_cmp++; if (mem[500 + j] !== DW'(j + 10)) begin n_bad++; $display("FAIL rt_plain ch=%0d j=%0d got %0d want %0d", ch, j, mem[500 + j], j + 10); end
      end
    end
  endtask

  task automatic test_len_zero();
    int cyc, bsy, rds, wrs, both; bit e;
    run_cmd(1, 0, 800, 900, 0, DW'($urandom), '0, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL len0_latency got %0d want 1", cyc); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL len0_err got %0b want 1", e); end
    n_cmp++; if (rds !== 0 || wrs !== 0 || bsy !== 0) begin n_bad++; $display("FAIL len0_activity got rd=%0d wr=%0d busy=%0d want 0/0/0", rds, wrs, bsy); end
    put(800, DW'($urandom));
    model_cmd(1, 0, 800, 900, 1, 19'h1234, '0);
    run_cmd(1, 0, 800, 900, 1, 19'h1234, '0, 0, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL len1_err_clear got %0b want 0", e); end
    n_cmp++; if (mem[900] !== exp_mem[900]) begin n_bad++; $display("FAIL len1_data got %0h want %0h", mem[900], exp_mem[900]); end
  endtask

  task automatic test_random();
    int cyc, bsy, rds, wrs, both; bit e;
    int s, d, l; bit enc, ch, tog; logic [DW-1:0] k, v;
    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(20, 1);
      s = (t == 2) ? MSZ - 5 : $urandom_range(MSZ - 1, 0);
      d = (t == 3) ? s : ((t == 4) ? MSZ - 3 : $urandom_range(MSZ - 1, 0));
      enc = 1'($urandom); ch = 1'($urandom); tog = (t >= 5);
      k = DW'($urandom); v = DW'($urandom);
      for (int j = 0; j < l; j++) put(s + j, DW'($urandom));
      model_cmd(enc, ch, s, d, l, k, v);
      run_cmd(enc, ch, s, d, l, k, v, tog, cyc, bsy, e, rds, wrs, both);
      n_cmp++; if (cyc !== 3 * l + 1) begin n_bad++; $display("FAIL rand_latency t=%0d got %0d want %0d", t, cyc, 3 * l + 1); end
      n_cmp++; if (rds !== l || wrs !== l || both !== 0) begin n_bad++; $display("FAIL rand_strobes t=%0d got rd=%0d wr=%0d both=%0d want %0d/%0d/0", t, rds, wrs, both, l, l); end
      for (int j = 0; j < l; j++) begin
        n_cmp++; if (mem[(d + j) % MSZ] !== exp_mem[(d + j) % MSZ]) begin n_bad++; $display("FAIL rand_data t=%0d j=%0d got %0h want %0h", t, j, mem[(d + j) % MSZ], exp_mem[(d + j) % MSZ]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bsy, rds, wrs, both, w0; bit e;
    logic [DW-1:0] k, v;
    k = DW'($urandom); v = DW'($urandom);
    for (int j = 0; j < 8; j++) begin
      put(1000 + j, DW'($urandom));
      put(1100 + j, DW'(19'h11111 + j));
    end
    model_cmd(1, 1, 1000, 1100, 3, k, v);
    w0 = wr_total;
    @(negedge clk);
    encrypt = 1'b1; chain_en = 1'b1; src_addr = AW'(1000); dst_addr = AW'(1100);
    len = LW'(8); key = k; iv = v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_cmp++; if (busy !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL mid_pre_state got busy=%0b rd=%0b wr=%0b want 1/0/0", busy, mem_rd_en, mem_wr_en); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({busy, done, err, mem_rd_en, mem_wr_en} !== 5'b0) begin n_bad++; $display("FAIL mid_rst_ctrl got %b want 00000", {busy, done, err, mem_rd_en, mem_wr_en}); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL mid_rst_data got %0h/%0h want 0/0", mem_addr, mem_wdata); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (wr_total - w0 !== 3) begin n_bad++; $display("FAIL mid_write_count got %0d want 3", wr_total - w0); end
    for (int j = 0; j < 8; j++) begin
      n_cmp++; if (mem[1100 + j] !== exp_mem[1100 + j]) begin n_bad++; $display("FAIL mid_data j=%0d got %0h want %0h", j, mem[1100 + j], exp_mem[1100 + j]); end
    end
    model_cmd(0, 1, 1000, 1200, 5, k, v);
    run_cmd(0, 1, 1000, 1200, 5, k, v, 1, cyc, bsy, e, rds, wrs, both);
    n_cmp++; if (cyc !== 16 || e !== 1'b0) begin n_bad++; $display("FAIL mid_after_cmd got cyc=%0d err=%0b want 16/0", cyc, e); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (mem[1200 + j] !== exp_mem[1200 + j]) begin n_bad++; $display("FAIL mid_after_data j=%0d got %0h want %0h", j, mem[1200 + j], exp_mem[1200 + j]); end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; encrypt = 1'b0; chain_en = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; key = '0; iv = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    test_reset();
    test_basic();
    test_chain();
    test_rotate_wrap();
    test_round_trip();
    test_len_zero();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
